// File: rtl/gl_decode_pkg.sv
// Shared opcode, operand-count and state definitions for the gl_decode stage.
package gl_decode_pkg;

    localparam int NOPS_W = 5;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_VERTEX     = 8'h03;
    localparam logic [7:0] OP_COLOR      = 8'h04;
    localparam logic [7:0] OP_MULTMATRIX = 8'h11;
    localparam logic [7:0] OP_LOADMATRIX = 8'h13;
    localparam logic [7:0] OP_ROTATE     = 8'h16;
    localparam logic [7:0] OP_SCALE      = 8'h17;
    localparam logic [7:0] OP_TRANSLATE  = 8'h18;
    localparam logic [7:0] OP_VIEWPORT   = 8'h19;
    localparam logic [7:0] OP_FRUSTUM    = 8'h1A;

    localparam logic [NOPS_W-1:0] NOPS_VERTEX   = 5'd3;
    localparam logic [NOPS_W-1:0] NOPS_COLOR    = 5'd3;
    localparam logic [NOPS_W-1:0] NOPS_MATRIX   = 5'd16;
    localparam logic [NOPS_W-1:0] NOPS_VIEWPORT = 5'd4;
    localparam logic [NOPS_W-1:0] NOPS_FRUSTUM  = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOLD   = 2'd3
    } dec_state_t;

endpackage

// File: rtl/gl_decode_if.sv
// Command handshake from decode to the transform/raster back end.
interface gl_decode_if
    import gl_decode_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               cmd_opcode;
    logic [NOPS_W-1:0]        cmd_nops;
    logic [MAX_OPS*WIDTH-1:0] cmd_operands;

    modport master (
        output cmd_valid, cmd_opcode, cmd_nops, cmd_operands,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_nops, cmd_operands,
        output cmd_ready
    );
endinterface

// File: rtl/gl_opnd_count.sv
// Combinational opcode -> operand-count lookup; NOP and unknown opcodes map to 0.
module gl_opnd_count
    import gl_decode_pkg::*;
(
    input  logic [7:0]        opcode,
    output logic [NOPS_W-1:0] nops
);
    always_comb begin
        nops = '0;
        case (opcode)
            OP_VERTEX:     nops = NOPS_VERTEX;
            OP_COLOR:      nops = NOPS_COLOR;
            OP_MULTMATRIX,
            OP_LOADMATRIX,
            OP_ROTATE,
            OP_SCALE,
            OP_TRANSLATE:  nops = NOPS_MATRIX;
            OP_VIEWPORT:   nops = NOPS_VIEWPORT;
            OP_FRUSTUM:    nops = NOPS_FRUSTUM;
            default:       nops = '0;
        endcase
    end
endmodule

// File: rtl/gl_decode.sv
// Decode stage: gathers an opcode's operand words from BRAM and emits one packed command.
module gl_decode
    import gl_decode_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inst_in,
    input  logic [WIDTH-1:0] opnd_base,
    output logic             stall_out,
    output logic             bram_en,
    output logic [WIDTH-1:0] bram_addr,
    input  logic [WIDTH-1:0] bram_data,
    gl_decode_if.master      cmd
);
    localparam int SW = $clog2(MAX_OPS);

    dec_state_t        state_reg;
    logic              stall_reg;
    logic              bram_en_reg;
    logic [WIDTH-1:0]  bram_addr_reg;
    logic [WIDTH-1:0]  base_reg;
    logic [NOPS_W-1:0] issue_idx_reg;
    logic [SW-1:0]     cap_idx_reg;
    logic              rd_pend_reg;
    logic              valid_reg;
    logic [7:0]        opcode_reg;
    logic [NOPS_W-1:0] nops_reg;
    logic [WIDTH-1:0]  ops_reg [MAX_OPS];

    logic [NOPS_W-1:0] lut_nops;
    logic              unused_inst_bits;

    assign unused_inst_bits = |inst_in[WIDTH-1:8];

    gl_opnd_count u_count (
        .opcode (inst_in[7:0]),
        .nops   (lut_nops)
    );

    // Read issued while bram_en is high returns data the next cycle; rd_pend_reg marks that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            stall_reg     <= 1'b0;
            bram_en_reg   <= 1'b0;
            bram_addr_reg <= '0;
            base_reg      <= '0;
            issue_idx_reg <= '0;
            cap_idx_reg   <= '0;
            rd_pend_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            opcode_reg    <= '0;
            nops_reg      <= '0;
            for (int i = 0; i < MAX_OPS; i++) ops_reg[i] <= '0;
        end else begin
            rd_pend_reg <= bram_en_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (inst_in[7:0] != OP_NOP) begin
                        opcode_reg  <= inst_in[7:0];
                        nops_reg    <= lut_nops;
                        stall_reg   <= 1'b1;
                        cap_idx_reg <= '0;
                        for (int i = 0; i < MAX_OPS; i++) ops_reg[i] <= '0;
                        if (lut_nops == '0) begin
                            valid_reg <= 1'b1;
                            state_reg <= ST_HOLD;
                        end else begin
                            // First read goes out on the accepting edge itself.
                            bram_en_reg   <= 1'b1;
                            bram_addr_reg <= opnd_base;
                            base_reg      <= opnd_base;
                            issue_idx_reg <= NOPS_W'(1);
                            state_reg     <= ST_GATHER;
                        end
                    end
                end
                ST_GATHER: begin
                    if (rd_pend_reg) begin
                        ops_reg[cap_idx_reg] <= bram_data;
                        cap_idx_reg          <= cap_idx_reg + 1'b1;
                    end
                    if (issue_idx_reg == nops_reg) begin
                        bram_en_reg <= 1'b0;
                        state_reg   <= ST_DRAIN;
                    end else begin
                        bram_addr_reg <= base_reg + WIDTH'(issue_idx_reg);
                        issue_idx_reg <= issue_idx_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ops_reg[cap_idx_reg] <= bram_data;
                    cap_idx_reg          <= cap_idx_reg + 1'b1;
                    valid_reg            <= 1'b1;
                    state_reg            <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cmd.cmd_ready) begin
                        valid_reg <= 1'b0;
                        stall_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign stall_out      = stall_reg;
    assign bram_en        = bram_en_reg;
    assign bram_addr      = bram_addr_reg;
    assign cmd.cmd_valid  = valid_reg;
    assign cmd.cmd_opcode = opcode_reg;
    assign cmd.cmd_nops   = nops_reg;

    for (genvar gi = 0; gi < MAX_OPS; gi++) begin : g_pack
        assign cmd.cmd_operands[gi*WIDTH +: WIDTH] = ops_reg[gi];
    end

endmodule

// File: tb/tb_gl_decode.sv
// Randomized and directed bench for gl_decode against a transaction-timeline model.
module tb_gl_decode;
    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  inst_in = '0;
    logic [W-1:0]  opnd_base = '0;
    logic          stall_out;
    logic          bram_en;
    logic [W-1:0]  bram_addr;
    logic [W-1:0]  bram_data = '0;

    gl_decode_if #(.WIDTH(W), .MAX_OPS(N)) cmd_if ();

    gl_decode #(.WIDTH(W), .MAX_OPS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_in   (inst_in),
        .opnd_base (opnd_base),
        .stall_out (stall_out),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .cmd       (cmd_if.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'hA5C30F17 ^ {a[15:0], a[31:16]};
    endfunction

    // BRAM: one-cycle registered read; garbage on the bus when not reading.
    always @(posedge clk) bram_data <= bram_en ? mem_word(bram_addr) : $urandom;

    function automatic int ref_nops(input logic [7:0] op);
        if (op == 8'h03 || op == 8'h04) return 3;
        if (op == 8'h11 || op == 8'h13 || (op >= 8'h16 && op <= 8'h18)) return 16;
        if (op == 8'h19) return 4;
        if (op == 8'h1A) return 6;
        return 0;
    endfunction

    // Model: a command is a timeline measured in cycles since the accepting edge.
    bit          m_active = 0;
    bit          m_fresh  = 1;
    int          m_age    = 0;
    int          m_n      = 0;
    logic [7:0]  m_op     = '0;
    logic [31:0] m_base   = '0;

    function automatic bit exp_valid();
        return m_active && (m_age >= ((m_n == 0) ? 0 : m_n + 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_active = 0;
            m_fresh  = 1;
        end else if (!m_active) begin
            if (inst_in[7:0] != 8'h00) begin
                m_active = 1;
                m_fresh  = 0;
                m_age    = 0;
                m_op     = inst_in[7:0];
                m_n      = ref_nops(inst_in[7:0]);
                m_base   = opnd_base;
            end
        end else if (exp_valid() && cmd_if.cmd_ready) begin
            m_active = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_all();
        bit en_e;
        en_e = m_active && (m_age < m_n);
        chk("stall_out", {31'd0, stall_out}, {31'd0, m_active});
        chk("bram_en", {31'd0, bram_en}, {31'd0, en_e});
        if (en_e) chk("bram_addr", bram_addr, m_base + 32'(m_age));
        chk("cmd_valid", {31'd0, cmd_if.cmd_valid}, {31'd0, exp_valid()});
        if (exp_valid()) begin
            chk("cmd_opcode", {24'd0, cmd_if.cmd_opcode}, {24'd0, m_op});
            chk("cmd_nops", {27'd0, cmd_if.cmd_nops}, 32'(m_n));
            for (int i = 0; i < N; i++)
                chk($sformatf("operand%0d", i), cmd_if.cmd_operands[i*W +: W],
                    (i < m_n) ? mem_word(m_base + 32'(i)) : 32'd0);
        end
        if (!m_active && m_fresh) begin
            chk("fresh_opcode", {24'd0, cmd_if.cmd_opcode}, 32'd0);
            chk("fresh_nops", {27'd0, cmd_if.cmd_nops}, 32'd0);
            chk("fresh_addr", bram_addr, 32'd0);
            chk("fresh_operands", {31'd0, |cmd_if.cmd_operands}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Observations of the last issued command, for the literal pins.
    logic [31:0]    addr_q [$];
    int             lat;
    int             nvalid;
    logic [N*W-1:0] last_ops;
    logic [7:0]     last_opcode;
    logic [4:0]     last_nops;

    task automatic issue(input logic [7:0] op, input logic [31:0] base,
                         input int hold, input bit rnd_ready);
        int t;
        int hl;
        addr_q.delete();
        lat = 0; nvalid = 0; t = 0; hl = hold;
        inst_in   = {$urandom_range(0, 255), 16'h0, op};
        opnd_base = base;
        tick();
        t = 1;
        if (bram_en) addr_q.push_back(bram_addr);
        if (cmd_if.cmd_valid) begin lat = t; nvalid++; end
        while (m_active && t < 300) begin
            inst_in   = $urandom;
            opnd_base = $urandom;
            if (!exp_valid()) cmd_if.cmd_ready = 1'($urandom_range(0, 1));
            else if (hl > 0) begin cmd_if.cmd_ready = 1'b0; hl--; end
            else cmd_if.cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cmd_if.cmd_valid) begin
                last_ops    = cmd_if.cmd_operands;
                last_opcode = cmd_if.cmd_opcode;
                last_nops   = cmd_if.cmd_nops;
            end
            tick();
            t++;
            if (bram_en) addr_q.push_back(bram_addr);
            if (cmd_if.cmd_valid) begin
                nvalid++;
                if (lat == 0) lat = t;
            end
        end
        if (m_active) chk("handshake_timeout", 32'(t), 32'd0);
        inst_in = '0;
    endtask

    initial begin
        cmd_if.cmd_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("reset_stall", {31'd0, stall_out}, 32'd0);
        chk("reset_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);

        // VERTEX
        mem_ovr[32'h40] = 32'hA0A0_0001;
        mem_ovr[32'h41] = 32'hB0B0_0002;
        mem_ovr[32'h42] = 32'hC0C0_0003;
        issue(8'h03, 32'h40, 0, 0);
        chk("vtx_nreads", 32'(addr_q.size()), 32'd3);
        if (addr_q.size() == 3) begin
            chk("vtx_addr0", addr_q[0], 32'h40);
            chk("vtx_addr1", addr_q[1], 32'h41);
            chk("vtx_addr2", addr_q[2], 32'h42);
        end
        chk("vtx_latency", 32'(lat), 32'd5);
        chk("vtx_opcode", {24'd0, last_opcode}, 32'h03);
        chk("vtx_nops", {27'd0, last_nops}, 32'd3);
        chk("vtx_op0", last_ops[31:0], 32'hA0A0_0001);
        chk("vtx_op1", last_ops[63:32], 32'hB0B0_0002);
        chk("vtx_op2", last_ops[95:64], 32'hC0C0_0003);
        chk("vtx_hi_zero", {31'd0, |last_ops[N*W-1:96]}, 32'd0);
        tick();

        // LOADMATRIX with consumer stalled
        issue(8'h13, 32'h100, 10, 0);
        chk("lm_nreads", 32'(addr_q.size()), 32'd16);
        if (addr_q.size() == 16) begin
            chk("lm_first", addr_q[0], 32'h100);
            chk("lm_last", addr_q[15], 32'h10F);
        end
        chk("lm_valid_cycles", 32'(nvalid), 32'd11);
        chk("lm_nops", {27'd0, last_nops}, 32'd16);
        tick();

        // Zero-operand opcode
        issue(8'h07, 32'h55, 0, 0);
        chk("op07_latency", 32'(lat), 32'd1);
        chk("op07_reads", 32'(addr_q.size()), 32'd0);
        chk("op07_nops", {27'd0, last_nops}, 32'd0);

        // NOP is dropped
        inst_in = 32'h0000_FF00;
        repeat (4) begin
            tick();
            chk("nop_stall", {31'd0, stall_out}, 32'd0);
        end

        // FRUSTUM aborted by reset during the third read
        inst_in = 32'h1A; opnd_base = 32'h200;
        tick();
        inst_in = '0;
        for (int k = 0; k < 20 && !(bram_en && bram_addr == 32'h202); k++) tick();
        chk("fr_third_read", bram_addr, 32'h202);
        reset = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_en", {31'd0, bram_en}, 32'd0);
        chk("rst_addr", bram_addr, 32'd0);
        chk("rst_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        chk("rst_opcode", {24'd0, cmd_if.cmd_opcode}, 32'd0);
        chk("rst_nops", {27'd0, cmd_if.cmd_nops}, 32'd0);
        chk("rst_operands", {31'd0, |cmd_if.cmd_operands}, 32'd0);
        m_active = 0; m_fresh = 1;
        @(negedge clk);
        tick();
        reset = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        repeat (10) tick();

        // VIEWPORT across the address wrap, then VERTEX back to back
        issue(8'h19, 32'hFFFF_FFFE, 0, 0);
        chk("vp_nreads", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) begin
            chk("vp_addr0", addr_q[0], 32'hFFFF_FFFE);
            chk("vp_addr1", addr_q[1], 32'hFFFF_FFFF);
            chk("vp_addr2", addr_q[2], 32'h0);
            chk("vp_addr3", addr_q[3], 32'h1);
        end
        chk("vp_nops", {27'd0, last_nops}, 32'd4);
        chk("b2b_idle_stall", {31'd0, stall_out}, 32'd0);
        issue(8'h03, 32'h40, 0, 0);
        chk("b2b_latency", 32'(lat), 32'd5);

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            logic [7:0]  ops [12] = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17,
                                      8'h18, 8'h19, 8'h1A, 8'h00, 8'h07, 8'h2F};
            logic [7:0]  op;
            logic [31:0] base;
            op   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 11)];
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : $urandom;
            issue(op, base, $urandom_range(0, 3), 1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gl_decode.md
Name: gl_decode

Overview:
- Stage directly downstream of gl_fetch.
- Takes the registered instruction word and the operand base address from fetch.
- Gathers the opcode's fixed-count operand words from the instruction BRAM and packs opcode plus operands into one command.
- Hands the command to the transform/raster back end over a valid/ready handshake, and stalls fetch while busy.

Parameters:
- WIDTH, 32, instruction/operand/address word width
- MAX_OPS, 16, operand slots in the command buffer (largest opcode count)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- inst_in  in  WIDTH  instruction word from fetch; opcode in [7:0]
- opnd_base  in  WIDTH  word address of the first operand in BRAM
- stall_out  out  1  to fetch stall input; high = hold current instruction
- bram_en  out  1  BRAM read enable
- bram_addr  out  WIDTH  BRAM word read address
- bram_data  in  WIDTH  BRAM read data, valid one cycle after bram_en
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts the command
- cmd_opcode  out  8  opcode of the command
- cmd_nops  out  5  number of valid operands (0..16)
- cmd_operands  out  MAX_OPS*WIDTH  operand i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: stall_out, bram_en, bram_addr, cmd_valid, cmd_opcode, cmd_nops, cmd_operands.
  - Internal index counters are 0.
- Operand counts (nops):
  - 0x03 VERTEX, 0x04 COLOR: 3
  - 0x11 MULTMATRIX, 0x13 LOADMATRIX, 0x16 ROTATE, 0x17 SCALE, 0x18 TRANSLATE: 16
  - 0x19 VIEWPORT: 4
  - 0x1A FRUSTUM: 6
  - 0x00 NOP: dropped, no command
  - every other opcode: 0
- stall_out = (state != IDLE), registered.
- IDLE:
  - Every cycle in IDLE, inst_in is sampled and accepted.
  - opcode 0x00: remain in IDLE.
  - nops==0: latch opcode, cmd_nops=0, operands cleared; next state HOLD with cmd_valid=1.
  - nops>0: latch opcode and nops; clear all operand slots; issue_idx=0; base latched; next state GATHER.
- GATHER:
  - bram_en=1, bram_addr=base+issue_idx (mod 2^WIDTH), issue_idx increments each cycle.
  - From the second GATHER cycle on, bram_data is written into slot cap_idx, and cap_idx increments.
  - After issuing index nops-1, next state DRAIN.
- DRAIN:
  - bram_en=0; the last word is captured into slot nops-1.
  - cmd_valid=1 registered; next state HOLD.
- HOLD:
  - cmd_valid=1; cmd_* fields held stable.
  - On cmd_valid && cmd_ready: cmd_valid=0 and next state IDLE.
  - With cmd_ready low, hold indefinitely.
- Latency from the accepting edge:
  - nops>0: bram_en is high for exactly nops cycles, and cmd_valid is first visible nops+2 cycles after acceptance.
  - nops==0: cmd_valid is visible in the next cycle.
- Back-to-back: after handshake the block returns to IDLE. Fetch holds its next instruction and the block accepts it on the following edge, so there is one IDLE cycle between commands.
- Operand slots beyond nops read 0.
- cmd_ready while cmd_valid==0 is ignored.
- bram_data outside capture cycles is ignored.
- Reset asserted mid-GATHER or in HOLD aborts the command. No partial command is ever emitted after reset releases.
- Address wrap: base near 2^WIDTH-1 wraps modulo 2^WIDTH, with no error.

Decomposition:
- gl_defines.v gains:
  - opcode constants (OP_VERTEX..OP_FRUSTUM, OP_NOP)
  - per-opcode operand-count constants
  - decode state encodings (IDLE/GATHER/DRAIN/HOLD)
- Sub-module gl_opnd_count: combinational opcode[7:0] -> nops[4:0] lookup, reusable by any later assembler/checker.

Test Plan:
- VERTEX, inst_in=0x03, opnd_base=0x40, BRAM[0x40..0x42]=A,B,C, cmd_ready=1:
  - bram_addr 0x40,0x41,0x42 on consecutive cycles.
  - cmd_valid 5 cycles after accept, opcode 0x03, nops 3, operands A,B,C, slots 3..15 = 0.
- LOADMATRIX 0x13, base 0x100, cmd_ready held low 10 cycles:
  - 16 reads, 0x100..0x10F.
  - cmd_valid and all fields stable while stalled; stall_out high throughout.
  - One handshake, then IDLE.
- Opcode 0x07:
  - cmd_valid next cycle, nops 0, no bram_en pulse.
- Opcode 0x00:
  - No cmd_valid and no bram_en; stall_out stays 0.
- FRUSTUM with reset pulsed low during the third read:
  - All outputs 0 immediately.
  - After release, no command is emitted until a new instruction is accepted.
- VIEWPORT with base 0xFFFFFFFE:
  - Reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; nops 4.
  - Then a VERTEX back-to-back, accepted exactly one IDLE cycle after the handshake.
